ring_token_master: RTL and testbench
====================================

# ring_token_master

Single-instance ring stop that creates and recycles the ring Token slot used by Messenger, Locker and Barrier to append slots to the send train. It injects the first Token after reset. On each Token return it strips the Token, lets the train of N slots pass, then re-issues a fresh Token with count 0 in the next free slot. It sits on the ring at core MASTER_ID, in series with that core's other ring units; its drive signals merge with theirs in the core's ring output mux.

## Interface
- MASTER_ID, 0: core number placed in SrcDest of every emitted Token.
- INIT_DELAY, 16: cycles after reset before the first Token may be emitted (1..255).
- TIMEOUT, 4096: cycles without a Token before it is declared lost (watchdog build only; 2..65535).

- clock  in  1  ring clock
- reset  in  1  reset, synchronous, active-high
- RingIn  in  32  ring data of the current slot
- SlotTypeIn  in  4  slot type (Null=7, Token=1)
- SrcDestIn  in  4  slot source/destination
- tokenRingOut  out  32  ring data driven when tokenDriveRing=1
- tokenSlotTypeOut  out  4  slot type driven
- tokenSrcDestOut  out  4  SrcDest driven
- tokenDriveRing  out  1  this block owns the current slot
- tokenLost  out  1  one-cycle pulse when the watchdog fires
- rotations  out  16  Token returns seen, wraps at 65535->0

## Operation
- States: init, reissue, circulate, drain.
- init: a delay counter counts 0..INIT_DELAY-1, then goes to reissue.
- reissue: waits for SlotTypeIn==Null. In that slot the block drives Token, data 0, SrcDest=MASTER_ID, then goes to circulate. Non-Null slots pass untouched.
- circulate, Token arrives with RingIn[7:0]==0: block does not drive (Token passes on unchanged), rotations+1, stays in circulate.
- circulate, Token arrives with N=RingIn[7:0]!=0: block drives Null in that slot (absorbs the Token), loads the drain counter with N, rotations+1, goes to drain.
- drain: passes every slot untouched and decrements the counter each cycle. When counter==1, goes to reissue. Result: the train passes intact, and nodes cannot append because no Token is in flight.
- Data in RingIn[31:8] of the Token is ignored. When emitting, the block drives it to 0.
- When not driving, the outputs are pass-through: tokenRingOut=RingIn, tokenSlotTypeOut=SlotTypeIn, tokenSrcDestOut=SrcDestIn.
- Token seen in init, reissue or drain (duplicate Token): block drives Null to destroy it. No other effect; the state and counters are unchanged.
- rotations: 16-bit, modulo arithmetic.

## Timing
- Ring outputs are combinational from the current slot inputs and the registered state. Decisions take effect in the same cycle as the slot.
- All state, counters and rotations update on posedge clock.
- Reset: state=init, delay/drain/watchdog counters=0, rotations=0. Outputs after reset: tokenDriveRing=0, tokenLost=0, outputs pass-through.
- Reset asserted mid-drain or mid-circulate: back to init. Any Token then in flight is destroyed on arrival, because init absorbs Tokens.
- First Token emission: earliest at cycle INIT_DELAY after reset deasserts, in the first Null slot.
- Absorb-to-reissue: the block enters reissue N cycles after the absorbed Token slot. The new Token appears in the first Null slot at or after that point.

## Configuration
- RING_TOKEN_WATCHDOG_EN defined:
  - A watchdog counter runs only in circulate. It clears on entry to circulate and on every Token seen.
  - When it reaches TIMEOUT-1 with no Token: tokenLost pulses for 1 cycle, the counter clears, and the state goes to reissue.
- RING_TOKEN_WATCHDOG_EN undefined: no watchdog logic, tokenLost tied 0, circulate waits forever.

## Test plan
- Reset, ring all Null, INIT_DELAY=16 -> tokenDriveRing=1 with SlotType=1, data 0, SrcDest=MASTER_ID exactly at cycle 16; rotations=0.
- Token returns with count 0 -> no drive, token forwarded unchanged, rotations=1, still circulate.
- Token returns with count 3, followed by 3 train slots and then Null -> Token slot replaced by Null; the 3 train slots pass bit-exact; new Token (data 0) emitted in the 4th slot; rotations+1.
- Token count 2, train followed by a non-Null slot and then Null -> reissue waits and emits the Token in the first Null slot only.
- Second Token injected during drain -> driven to Null; drain length and rotations unaffected.
- With RING_TOKEN_WATCHDOG_EN, TIMEOUT=64, Token removed externally -> tokenLost pulses exactly once 64 cycles after the last Token seen, and a new Token is emitted in the next Null slot. Without the macro -> tokenLost stays 0 and no re-emission occurs.

Source files
------------

// File: rtl/ring_token_master.sv
// Ring stop that injects, recycles and (optionally) regenerates the ring Token slot.
// Optional watchdog: define RING_TOKEN_WATCHDOG_EN to enable Token-loss detection.
module ring_token_master #(
  parameter int MASTER_ID  = 0,
  parameter int INIT_DELAY = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SrcDestIn,
  output logic [31:0] tokenRingOut,
  output logic [3:0]  tokenSlotTypeOut,
  output logic [3:0]  tokenSrcDestOut,
  output logic        tokenDriveRing,
  output logic        tokenLost,
  output logic [15:0] rotations
);

  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_REISSUE   = 2'd1;
  localparam logic [1:0] ST_CIRCULATE = 2'd2;
  localparam logic [1:0] ST_DRAIN     = 2'd3;

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  localparam logic [7:0] INIT_LAST = 8'(INIT_DELAY - 1);
  localparam logic [3:0] MASTER_SD = 4'(MASTER_ID);

  // Elaboration-time guard on the configurable ranges.
  if (INIT_DELAY < 1 || INIT_DELAY > 255) begin : g_bad_init_delay
    $error("ring_token_master: INIT_DELAY out of range 1..255");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ring_token_master: TIMEOUT out of range 2..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [7:0]  delay_q, delay_d;
  logic [7:0]  drain_q, drain_d;
  logic [15:0] rotations_q, rotations_d;

  logic        is_token;
  logic        is_null;
  logic [7:0]  token_count;
  logic        emit_token;
  logic        kill_slot;
  logic        lost_pulse;

`ifdef RING_TOKEN_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
`endif

  assign is_token    = (SlotTypeIn == SLOT_TOKEN);
  assign is_null     = (SlotTypeIn == SLOT_NULL);
  assign token_count = RingIn[7:0];

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    drain_d     = drain_q;
    rotations_d = rotations_q;
    emit_token  = 1'b0;
    kill_slot   = 1'b0;
    lost_pulse  = 1'b0;
`ifdef RING_TOKEN_WATCHDOG_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      ST_INIT: begin
        // Any Token still circulating from before reset is destroyed here.
        if (is_token) begin
          kill_slot = 1'b1;
        end else begin
          kill_slot = 1'b0;
        end
        if (delay_q == INIT_LAST) begin
          state_d = ST_REISSUE;
          delay_d = 8'd0;
        end else begin
          delay_d = delay_q + 8'd1;
        end
      end

      ST_REISSUE: begin
        if (is_null) begin
          emit_token = 1'b1;
          state_d    = ST_CIRCULATE;
`ifdef RING_TOKEN_WATCHDOG_EN
          wd_d       = 16'd0;
`endif
        end else if (is_token) begin
          kill_slot = 1'b1;
        end else begin
          kill_slot = 1'b0;
        end
      end

      ST_CIRCULATE: begin
        if (is_token) begin
          rotations_d = rotations_q + 16'd1;
`ifdef RING_TOKEN_WATCHDOG_EN
          wd_d        = 16'd0;
`endif
          if (token_count != 8'd0) begin
            kill_slot = 1'b1;
            drain_d   = token_count;
            state_d   = ST_DRAIN;
          end else begin
            kill_slot = 1'b0;
          end
        end else begin
`ifdef RING_TOKEN_WATCHDOG_EN
          if (wd_q == WD_LAST) begin
            lost_pulse = 1'b1;
            wd_d       = 16'd0;
            state_d    = ST_REISSUE;
          end else begin
            wd_d = wd_q + 16'd1;
          end
`else
          lost_pulse = 1'b0;
`endif
        end
      end

      ST_DRAIN: begin
        // Duplicate Tokens are destroyed without disturbing the drain length.
        if (is_token) begin
          kill_slot = 1'b1;
        end else begin
          kill_slot = 1'b0;
        end
        drain_d = drain_q - 8'd1;
        if (drain_q <= 8'd1) begin
          state_d = ST_REISSUE;
          drain_d = 8'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_INIT;
        delay_d = 8'd0;
        drain_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    tokenRingOut     = RingIn;
    tokenSlotTypeOut = SlotTypeIn;
    tokenSrcDestOut  = SrcDestIn;
    tokenDriveRing   = 1'b0;
    if (emit_token) begin
      tokenRingOut     = 32'd0;
      tokenSlotTypeOut = SLOT_TOKEN;
      tokenSrcDestOut  = MASTER_SD;
      tokenDriveRing   = 1'b1;
    end else if (kill_slot) begin
      tokenRingOut     = 32'd0;
      tokenSlotTypeOut = SLOT_NULL;
      tokenSrcDestOut  = 4'd0;
      tokenDriveRing   = 1'b1;
    end else begin
      tokenDriveRing   = 1'b0;
    end
  end

  assign tokenLost = lost_pulse;
  assign rotations = rotations_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      delay_q     <= 8'd0;
      drain_q     <= 8'd0;
      rotations_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      drain_q     <= drain_d;
      rotations_q <= rotations_d;
    end
  end

`ifdef RING_TOKEN_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

endmodule

// File: tb/tb_ring_token_master.sv
// Scoreboard bench for ring_token_master; expected slot outputs are queued as each slot is driven.
module tb_ring_token_master;

  localparam int MASTER_ID  = 5;
  localparam int INIT_DELAY = 16;
  localparam int TIMEOUT    = 64;

  localparam logic [3:0] T_TOKEN = 4'd1;
  localparam logic [3:0] T_NULL  = 4'd7;

  localparam int K_PASS = 0;
  localparam int K_EMIT = 1;
  localparam int K_KILL = 2;

  logic        clock;
  logic        reset;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SrcDestIn;
  logic [31:0] tokenRingOut;
  logic [3:0]  tokenSlotTypeOut;
  logic [3:0]  tokenSrcDestOut;
  logic        tokenDriveRing;
  logic        tokenLost;
  logic [15:0] rotations;

  typedef struct packed {
    logic        drive;
    logic [3:0]  typ;
    logic        chk_payload;
    logic [31:0] data;
    logic [3:0]  sd;
    logic        lost;
    logic [15:0] rot;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] rot_exp  = 16'd0;

  ring_token_master #(
    .MASTER_ID(MASTER_ID), .INIT_DELAY(INIT_DELAY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn),
    .SrcDestIn(SrcDestIn), .tokenRingOut(tokenRingOut),
    .tokenSlotTypeOut(tokenSlotTypeOut), .tokenSrcDestOut(tokenSrcDestOut),
    .tokenDriveRing(tokenDriveRing), .tokenLost(tokenLost), .rotations(rotations)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One ring slot: drive inputs just after the edge and queue what the DUT must show.
  task automatic slot(input logic [3:0] t, input logic [3:0] sd, input logic [31:0] d,
                      input int kind, input logic lost);
    exp_t e;
    @(posedge clock);
    #1;
    reset      = 1'b0;
    SlotTypeIn = t;
    SrcDestIn  = sd;
    RingIn     = d;
    e.lost = lost;
    e.rot  = rot_exp;
    e.chk_payload = 1'b1;
    if (kind == K_EMIT) begin
      e.drive = 1'b1; e.typ = T_TOKEN; e.data = 32'd0; e.sd = 4'(MASTER_ID);
    end else if (kind == K_KILL) begin
      e.drive = 1'b1; e.typ = T_NULL; e.data = 32'd0; e.sd = 4'd0; e.chk_payload = 1'b0;
    end else begin
      e.drive = 1'b0; e.typ = t; e.data = d; e.sd = sd;
    end
    sb.push_back(e);
  endtask

  task automatic null_pass(input int n);
    for (int i = 0; i < n; i++) slot(T_NULL, 4'd0, 32'd0, K_PASS, 1'b0);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("drive", {31'd0, tokenDriveRing}, {31'd0, e.drive});
      check("slot_type", {28'd0, tokenSlotTypeOut}, {28'd0, e.typ});
      if (e.chk_payload) begin
        check("ring_data", tokenRingOut, e.data);
        check("src_dest", {28'd0, tokenSrcDestOut}, {28'd0, e.sd});
      end
      check("token_lost", {31'd0, tokenLost}, {31'd0, e.lost});
      check("rotations", {16'd0, rotations}, {16'd0, e.rot});
    end
  end

  initial begin
    reset = 1'b1;
    SlotTypeIn = T_NULL; SrcDestIn = 4'd0; RingIn = 32'd0;
    repeat (3) @(posedge clock);

    // Init window: a stray Token is destroyed; first emission exactly at cycle INIT_DELAY.
    null_pass(5);
    slot(T_TOKEN, 4'd3, 32'h1234_0000, K_KILL, 1'b0);
    null_pass(INIT_DELAY - 6);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);

    // Token returns with count 0: forwarded unchanged, upper data untouched.
    null_pass(3);
    slot(T_TOKEN, 4'(MASTER_ID), 32'hABCD_1200, K_PASS, 1'b0);
    rot_exp++;
    null_pass(2);

    // Count 3: absorb, 3 train slots bit-exact, fresh Token in the 4th slot.
    slot(T_TOKEN, 4'd2, 32'h00BE_EF03, K_KILL, 1'b0);
    rot_exp++;
    slot(4'd2, 4'd9, $urandom, K_PASS, 1'b0);
    slot(4'd3, 4'd1, $urandom, K_PASS, 1'b0);
    slot(4'd4, 4'd6, $urandom, K_PASS, 1'b0);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);

    // Count 2: non-Null slot after the train delays the reissue to the next Null.
    null_pass(1);
    slot(T_TOKEN, 4'd4, 32'h0000_0002, K_KILL, 1'b0);
    rot_exp++;
    slot(4'd2, 4'd8, $urandom, K_PASS, 1'b0);
    slot(4'd2, 4'd8, $urandom, K_PASS, 1'b0);
    slot(4'd5, 4'd7, 32'hCAFE_F00D, K_PASS, 1'b0);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);

    // Duplicate Token during drain: destroyed, drain length and rotations unchanged.
    slot(T_TOKEN, 4'd1, 32'h0000_0003, K_KILL, 1'b0);
    rot_exp++;
    slot(4'd2, 4'd3, $urandom, K_PASS, 1'b0);
    slot(T_TOKEN, 4'd2, 32'h0000_0005, K_KILL, 1'b0);
    slot(4'd2, 4'd3, $urandom, K_PASS, 1'b0);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);

    // Token seen while waiting to reissue is destroyed; count 1 boundary.
    slot(T_TOKEN, 4'd1, 32'h0000_0001, K_KILL, 1'b0);
    rot_exp++;
    slot(4'd3, 4'd3, $urandom, K_PASS, 1'b0);
    slot(T_TOKEN, 4'd6, 32'h0000_0000, K_KILL, 1'b0);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);

    // Token disappears after one count-0 return: watchdog fires TIMEOUT cycles later.
    null_pass(2);
    slot(T_TOKEN, 4'(MASTER_ID), 32'h0000_0000, K_PASS, 1'b0);
    rot_exp++;
    null_pass(TIMEOUT - 1);
`ifdef RING_TOKEN_WATCHDOG_EN
    slot(T_NULL, 4'd0, 32'd0, K_PASS, 1'b1);
    slot(T_NULL, 4'd0, 32'd0, K_EMIT, 1'b0);
    null_pass(3);
`else
    null_pass(12);
`endif

    // Reset while circulating: the in-flight Token is destroyed by init.
    @(posedge clock);
    #1;
    reset = 1'b1;
    SlotTypeIn = T_NULL; SrcDestIn = 4'd0; RingIn = 32'd0;
    rot_exp = 16'd0;
    slot(T_TOKEN, 4'd2, 32'h0000_0004, K_KILL, 1'b0);
    null_pass(3);

    repeat (2) @(posedge clock);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
